// File: rtl/param_pipe_adder_if.sv
// param_pipe_adder_if: valid/ready operand and result bus for param_pipe_adder
interface param_pipe_adder_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             op;
  logic             sat_en;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic [CNT_W-1:0] txn_count;
  modport master (
    output in_valid, a, b, cin, op, sat_en, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, txn_count
  );
  modport slave (
    input  in_valid, a, b, cin, op, sat_en, out_ready,
    output in_ready, out_valid, sum, cout, ovf, txn_count
  );
endinterface

// File: rtl/param_pipe_adder.sv
// param_pipe_adder: pipelined add/subtract with optional saturation, global-stall valid/ready and a handshake counter
module param_pipe_adder #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 3,
  parameter int CNT_W  = 16
) (
  input logic               clk,
  input logic               rst,
  param_pipe_adder_if.slave bus
);
  logic             w_advance;
  logic [WIDTH:0]   w_r;
  logic [WIDTH-1:0] w_sum;
  logic [STAGES-1:0] r_vld;
  logic [STAGES-1:0] r_cout;
  logic [WIDTH-1:0] r_sum [STAGES];
  logic [CNT_W-1:0] r_cnt;
  // Stall control and the arithmetic that feeds stage 0; bit WIDTH of w_r is carry for add and borrow for sub
  always_comb begin
    w_advance = !r_vld[STAGES-1] || bus.out_ready;
    w_r = bus.op ? {1'b0, bus.a} - {1'b0, bus.b} - {{WIDTH{1'b0}}, bus.cin}
                 : {1'b0, bus.a} + {1'b0, bus.b} + {{WIDTH{1'b0}}, bus.cin};
    w_sum = (w_r[WIDTH] && bus.sat_en) ? (bus.op ? '0 : '1) : w_r[WIDTH-1:0];
  end
  // Whole pipeline shifts together when the output slot is free or being taken
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld  <= '0;
      r_cout <= '0;
      for (int i = 0; i < STAGES; i++) r_sum[i] <= '0;
    end else if (w_advance) begin
      r_vld[0]  <= bus.in_valid;
      r_cout[0] <= w_r[WIDTH];
      r_sum[0]  <= w_sum;
      for (int i = 1; i < STAGES; i++) begin
        r_vld[i]  <= r_vld[i-1];
        r_cout[i] <= r_cout[i-1];
        r_sum[i]  <= r_sum[i-1];
      end
    end
  end
  // Count completed output handshakes, wrapping naturally at the counter width
  always_ff @(posedge clk) begin
    if (rst) r_cnt <= '0;
    else if (r_vld[STAGES-1] && bus.out_ready) r_cnt <= r_cnt + CNT_W'(1);
  end
  assign bus.in_ready  = w_advance;
  assign bus.out_valid = r_vld[STAGES-1];
  assign bus.sum       = r_sum[STAGES-1];
  assign bus.cout      = r_cout[STAGES-1];
  assign bus.ovf       = r_cout[STAGES-1];
  assign bus.txn_count = r_cnt;
endmodule

// File: tb/tb_param_pipe_adder.sv
// tb_param_pipe_adder: directed-vector bench for param_pipe_adder
module tb_param_pipe_adder;
  logic clk = 0;
  logic rst = 1;
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;
  param_pipe_adder_if #(.WIDTH(8), .CNT_W(16)) bus ();
  param_pipe_adder_if #(.WIDTH(8), .CNT_W(4))  bus2 ();
  param_pipe_adder #(.WIDTH(8), .STAGES(3), .CNT_W(16)) dut  (.clk(clk), .rst(rst), .bus(bus));
  param_pipe_adder #(.WIDTH(8), .STAGES(3), .CNT_W(4))  dut2 (.clk(clk), .rst(rst), .bus(bus2));

  task automatic do_reset;
    @(negedge clk);
    rst = 1;
    bus.in_valid = 0;
    bus2.in_valid = 0;
    @(negedge clk);
    rst = 0;
  endtask

  task automatic run_one(input logic [7:0] a, input logic [7:0] b, input logic cin, input logic op,
                         input logic sat, output logic [7:0] s, output logic co, output logic ov,
                         output logic got);
    int n = 0;
    s = 'x; co = 'x; ov = 'x; got = 0;
    @(negedge clk);
    bus.a = a; bus.b = b; bus.cin = cin; bus.op = op; bus.sat_en = sat;
    bus.in_valid = 1; bus.out_ready = 1;
    @(negedge clk);
    bus.in_valid = 0;
    while (!got && n < 10) begin
      if (bus.out_valid) begin
        got = 1; s = bus.sum; co = bus.cout; ov = bus.ovf;
      end else begin
        @(negedge clk);
        n++;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1;
    bus.out_ready = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.txn_count !== 16'd0) begin errors++; $display("FAIL reset_txn_count: got %0d expected 0", bus.txn_count); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
    bus.a = 3; bus.b = 4; bus.cin = 0; bus.op = 0; bus.sat_en = 0; bus.in_valid = 1;
    @(negedge clk);
    bus.in_valid = 0;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL first_lat_e0: got %b expected 0", bus.out_valid); end
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL first_lat_e1: got %b expected 0", bus.out_valid); end
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL first_lat_e2: got %b expected 1", bus.out_valid); end
    checks++; if (bus.sum !== 8'd7) begin errors++; $display("FAIL first_sum: got %0d expected 7", bus.sum); end
    checks++; if (bus.cout !== 1'b0) begin errors++; $display("FAIL first_cout: got %b expected 0", bus.cout); end
    @(negedge clk);
    checks++; if (bus.txn_count !== 16'd1) begin errors++; $display("FAIL first_txn: got %0d expected 1", bus.txn_count); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL first_drain: got %b expected 0", bus.out_valid); end
  endtask

  task automatic test_wrap_sat;
    logic [7:0] va [7] = '{8'd200, 8'd200, 8'd5, 8'd5, 8'd9, 8'd255, 8'd7};
    logic [7:0] vb [7] = '{8'd100, 8'd100, 8'd9, 8'd9, 8'd5, 8'd0, 8'd7};
    logic       vc [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic       vo [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic       vs [7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [7:0] es [7] = '{8'd44, 8'd255, 8'd251, 8'd0, 8'd3, 8'd0, 8'd255};
    logic       ec [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [7:0] s;
    logic co, ov, got;
    for (int k = 0; k < 7; k++) begin
      run_one(va[k], vb[k], vc[k], vo[k], vs[k], s, co, ov, got);
      checks++; if (got !== 1'b1) begin errors++; $display("FAIL arith_timeout[%0d]: got no out_valid expected out_valid within 10 cycles", k); end
      checks++; if (s !== es[k]) begin errors++; $display("FAIL arith_sum[%0d]: got %0d expected %0d", k, s, es[k]); end
      checks++; if (co !== ec[k]) begin errors++; $display("FAIL arith_cout[%0d]: got %b expected %b", k, co, ec[k]); end
      checks++; if (ov !== ec[k]) begin errors++; $display("FAIL arith_ovf[%0d]: got %b expected %b", k, ov, ec[k]); end
    end
  endtask

  task automatic test_back_pressure;
    int sent = 0;
    int recv = 0;
    int c = 0;
    logic [7:0] hold = '0;
    logic stalled = 0;
    logic exp_rdy;
    do_reset();
    bus.cin = 0; bus.op = 0; bus.sat_en = 0;
    while (recv < 16 && c < 200) begin
      @(negedge clk);
      bus.out_ready = !(c >= 6 && c < 10);
      #1;
      if (stalled) begin
        checks++; if (bus.out_valid !== 1'b1 || bus.sum !== hold) begin errors++; $display("FAIL bp_hold c=%0d: got valid=%b sum=%0d expected valid=1 sum=%0d", c, bus.out_valid, bus.sum, hold); end
      end
      exp_rdy = !(bus.out_valid && !bus.out_ready);
      checks++; if (bus.in_ready !== exp_rdy) begin errors++; $display("FAIL bp_in_ready c=%0d: got %b expected %b", c, bus.in_ready, exp_rdy); end
      if (bus.out_valid && bus.out_ready) begin
        checks++; if (bus.sum !== 8'(2 * recv)) begin errors++; $display("FAIL bp_sum[%0d]: got %0d expected %0d", recv, bus.sum, 2 * recv); end
        recv++;
      end
      stalled = bus.out_valid && !bus.out_ready;
      hold = bus.sum;
      bus.in_valid = sent < 16;
      bus.a = 8'(sent);
      bus.b = 8'(sent);
      if (bus.in_valid && bus.in_ready) sent++;
      c++;
    end
    bus.in_valid = 0;
    checks++; if (recv !== 16) begin errors++; $display("FAIL bp_recv_count: got %0d expected 16", recv); end
    @(negedge clk);
    checks++; if (bus.txn_count !== 16'd16) begin errors++; $display("FAIL bp_txn_count: got %0d expected 16", bus.txn_count); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_no_extra: got %b expected 0", bus.out_valid); end
  endtask

  task automatic test_back_to_back;
    logic exp_v;
    int k;
    do_reset();
    bus.out_ready = 1; bus.cin = 0; bus.sat_en = 0;
    for (int c = 0; c < 21; c++) begin
      @(negedge clk);
      if (c >= 1) begin
        exp_v = c >= 3 && c <= 18;
        checks++; if (bus.out_valid !== exp_v) begin errors++; $display("FAIL b2b_valid c=%0d: got %b expected %b", c, bus.out_valid, exp_v); end
        if (exp_v) begin
          k = c - 3;
          checks++; if (bus.sum !== 8'(k[0] ? 9 * k : 11 * k)) begin errors++; $display("FAIL b2b_sum[%0d]: got %0d expected %0d", k, bus.sum, k[0] ? 9 * k : 11 * k); end
        end
      end
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready c=%0d: got %b expected 1", c, bus.in_ready); end
      bus.in_valid = c < 16;
      bus.a = 8'(c * 10);
      bus.b = 8'(c);
      bus.op = c[0];
    end
    checks++; if (bus.txn_count !== 16'd16) begin errors++; $display("FAIL b2b_txn_count: got %0d expected 16", bus.txn_count); end
  endtask

  task automatic test_reset_mid;
    bus.out_ready = 1; bus.cin = 0; bus.op = 0; bus.sat_en = 0; bus.b = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      bus.a = 8'(c + 1);
      bus.in_valid = 1;
    end
    @(negedge clk);
    bus.in_valid = 0;
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL rmid_pre_valid: got %b expected 1", bus.out_valid); end
    rst = 1;
    @(negedge clk);
    rst = 0;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.txn_count !== 16'd0) begin errors++; $display("FAIL rmid_txn: got %0d expected 0", bus.txn_count); end
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rmid_ghost c=%0d: got %b expected 0", c, bus.out_valid); end
    end
    checks++; if (bus.txn_count !== 16'd0) begin errors++; $display("FAIL rmid_txn_end: got %0d expected 0", bus.txn_count); end
  endtask

  task automatic test_cnt_wrap;
    do_reset();
    bus2.out_ready = 1; bus2.cin = 0; bus2.op = 0; bus2.sat_en = 0; bus2.a = 1; bus2.b = 1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (c == 10) begin
        checks++; if (bus2.txn_count !== 4'd7) begin errors++; $display("FAIL wrap_mid: got %0d expected 7", bus2.txn_count); end
      end
      bus2.in_valid = c < 16;
    end
    checks++; if (bus2.txn_count !== 4'd0) begin errors++; $display("FAIL wrap_16: got %0d expected 0", bus2.txn_count); end
    bus2.in_valid = 1;
    @(negedge clk);
    bus2.in_valid = 0;
    repeat (4) @(negedge clk);
    checks++; if (bus2.txn_count !== 4'd1) begin errors++; $display("FAIL wrap_17: got %0d expected 1", bus2.txn_count); end
  endtask

  initial begin
    bus.in_valid = 0; bus.a = 0; bus.b = 0; bus.cin = 0; bus.op = 0; bus.sat_en = 0; bus.out_ready = 1;
    bus2.in_valid = 0; bus2.a = 0; bus2.b = 0; bus2.cin = 0; bus2.op = 0; bus2.sat_en = 0; bus2.out_ready = 1;
    test_reset();
    test_wrap_sat();
    test_back_pressure();
    test_back_to_back();
    test_reset_mid();
    test_cnt_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/param_pipe_adder.md
Name: param_pipe_adder

Overview:
- Parametrised, pipelined successor to the single-cycle adder DUT driven by the adder environment.
- Adds width and latency parameters, subtract mode, optional saturation, and a valid/ready handshake with back-pressure.
- Adds a completed-transaction counter so the scoreboard can cross-check packet counts against the generator.
- Sits between the driver-side and monitor-side of the adder interface.

Parameters:
- WIDTH, 8, operand/result width in bits (>=2)
- STAGES, 3, pipeline depth = latency in cycles with no stall (>=1)
- CNT_W, 16, width of the transaction counter

Ports:
- clk  input  1  the block's single clock; all state updates on its rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operand beat valid
- in_ready  output  1  block can accept a beat this cycle
- a  input  WIDTH  operand A, unsigned
- b  input  WIDTH  operand B, unsigned
- cin  input  1  carry-in (op=0) or borrow-in (op=1)
- op  input  1  0 = add, 1 = subtract
- sat_en  input  1  1 = saturate on overflow/underflow
- out_valid  output  1  result beat valid
- out_ready  input  1  downstream accepts result
- sum  output  WIDTH  result
- cout  output  1  add: carry-out; sub: borrow-out
- ovf  output  1  result exceeded the unsigned range (equals cout)
- txn_count  output  CNT_W  count of completed output handshakes

Behaviour:
- Reset: synchronous, active-high. While rst=1 at a clk edge, all stage valid bits, out_valid, sum, cout, ovf and txn_count clear to 0. Data registers also clear to 0.
- During and right after reset, in_ready=1, because out_valid=0.
- Reset mid-operation discards every in-flight beat. No output handshake completes in a cycle where rst=1.
- Global-stall pipeline: advance = !out_valid || out_ready.
  - in_ready = advance, combinational; there is no path from in_valid to in_ready.
  - When advance=1, every stage shifts one position. Stage 0 captures {in_valid, data}; an input handshake is in_valid && in_ready.
  - When advance=0, all stages hold. Output signals stay stable while out_valid=1 and out_ready=0.
- Bubbles are not compressed: an idle input cycle while advancing inserts an invalid slot.
- Latency: a beat accepted at edge N appears with out_valid=1 after edge N+STAGES-1, with no stall. Throughput is 1 beat/cycle when out_ready is held 1.
- Arithmetic is computed before the stage-0 register, in WIDTH+1 bits:
  - op=0: r = a + b + cin. cout = r[WIDTH].
  - op=1: r = a - b - cin. cout = 1 iff a < b + cin, i.e. a borrow occurred.
  - ovf = cout.
  - sat_en=0: sum = r[WIDTH-1:0], wrap-around.
  - sat_en=1 and ovf=1: sum = all ones for add, 0 for sub. cout and ovf still report 1.
- op, sat_en and cin are sampled with the operands in the same handshake cycle.
- txn_count increments by 1 on each cycle with out_valid && out_ready && !rst, and wraps from 2^CNT_W-1 to 0.
- Simultaneous input and output handshakes in one cycle are legal and preserve both beats.
- Output payload is don't-care-but-stable when out_valid=0; the bench checks it only when valid.

Test Plan (WIDTH=8, STAGES=3, CNT_W=16 unless stated):
- Reset: hold rst=1 for 2 cycles, then release -> out_valid=0, txn_count=0, in_ready=1. First beat a=3, b=4, cin=0, op=0 accepted at edge 0 -> sum=7, cout=0, out_valid=1 after edge 2.
- Wrap vs saturate:
  - a=200, b=100, op=0, sat_en=0 -> sum=44, cout=1, ovf=1.
  - Same operands with sat_en=1 -> sum=255, ovf=1.
  - a=5, b=9, op=1, cin=1, sat_en=0 -> sum=251, cout=1.
  - Same operands with sat_en=1 -> sum=0.
- Back-pressure: stream 16 beats a=i, b=i; drop out_ready low for 4 cycles mid-stream -> in_ready=0 during the stall, sum/out_valid held stable, no beat lost or duplicated, outputs 2*i in order, txn_count=16 at the end.
- Full throughput: 16 back-to-back beats with out_ready=1 -> 16 consecutive out_valid cycles starting 2 cycles after the first accept.
- Reset mid-stream: assert rst with 3 beats in flight -> out_valid=0 on the next cycle, none of those 3 beats ever emerges, txn_count=0.
- Counter wrap: CNT_W=4, send 17 beats -> txn_count=1.
